// File: rtl/ddr_req_issuer.sv
// Two-client request issuer for the x32 DDR command FSM: arbitrates the camera write
// port against the display read port and paces command strobes on the controller busy.
module ddr_req_issuer #(
  parameter int ADDR_W         = 22,
  parameter bit AUTO_PRE       = 1'b1,
  parameter int MAX_WR_STREAK  = 4,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_urgent,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              timeout_err
);

  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
  localparam logic [3:0] CMD_RD = AUTO_PRE ? 4'b0011 : 4'b0001;
  localparam logic [3:0] CMD_WR = AUTO_PRE ? 4'b0100 : 4'b0010;
  // Timer starts at 0 in the first WAIT_ACCEPT cycle, so this value puts the
  // timeout_err pulse exactly ACCEPT_TIMEOUT cycles after the strobe cycle.
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACCEPT_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;

  state_t              state;
  grant_t              grant;
  logic [STREAK_W-1:0] wr_streak;
  logic [3:0]          timer;

  logic can_arb;
  logic pick_rd;
  logic pick_wr;

  // No arbitration while an ack is showing, so a client gets one cycle to drop its request.
  always_comb begin
    can_arb = 1'b0;
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (init_done && !busy && !wr_ack && !rd_ack && (wr_req || rd_req)) begin
      can_arb = 1'b1;
      pick_rd = rd_req && (rd_urgent || !wr_req || (wr_streak == STREAK_MAX));
      pick_wr = wr_req && !pick_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= GNT_NONE;
      wr_streak   <= '0;
      timer       <= '0;
      cmd         <= 4'b0000;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      timeout_err <= 1'b0;
      if (!init_done) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (can_arb) begin
              cmd_valid <= 1'b1;
              state     <= ISSUE;
              if (pick_rd) begin
                grant     <= GNT_RD;
                cmd       <= CMD_RD;
                cmd_addr  <= rd_addr;
                wr_streak <= '0;
              end else if (pick_wr) begin
                grant    <= GNT_WR;
                cmd      <= CMD_WR;
                cmd_addr <= wr_addr;
                if (rd_req && (wr_streak != STREAK_MAX))
                  wr_streak <= wr_streak + STREAK_W'(1);
              end
            end
          end
          ISSUE: begin
            timer <= '0;
            state <= WAIT_ACCEPT;
          end
          WAIT_ACCEPT: begin
            if (busy) begin
              state <= WAIT_DONE;
            end else if (timer == TIMEOUT_LAST) begin
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              timer <= timer + 4'd1;
            end
          end
          WAIT_DONE: begin
            if (!busy) begin
              wr_ack <= (grant == GNT_WR);
              rd_ack <= (grant == GNT_RD);
              grant  <= GNT_NONE;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_req_issuer.sv
// Directed bench for ddr_req_issuer with a small controller model that raises busy
// one cycle after each strobe for a programmable number of cycles.
module tb_ddr_req_issuer;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_urgent;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic          wr_ack;
  logic          rd_ack;
  logic          timeout_err;
  logic          busy;

  logic model_on   = 1'b0;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  int   model_len  = 12;
  int   busy_left  = 0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dual   = 0;
  int b2b    = 0;
  logic prev_valid = 1'b0;

  logic [31:0] s_cmd[$];
  logic [31:0] s_addr[$];
  logic [31:0] s_cyc[$];
  logic [31:0] wa_cyc[$];
  logic [31:0] ra_cyc[$];
  logic [31:0] te_cyc[$];

  localparam int EV_WR = 0, EV_RD = 1, EV_STROBE = 2, EV_TO = 3;

  assign busy = model_busy | force_busy;

  ddr_req_issuer #(.ADDR_W(AW), .AUTO_PRE(1'b1), .MAX_WR_STREAK(4), .ACCEPT_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .busy(busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_urgent(rd_urgent), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Controller model: busy covers the N cycles that follow each strobe cycle.
  always @(negedge clk) begin
    if (!rst_n || !model_on) begin
      busy_left  = 0;
      model_busy = 1'b0;
    end else begin
      if (busy_left > 0) begin
        model_busy = 1'b1;
        busy_left  = busy_left - 1;
      end else begin
        model_busy = 1'b0;
      end
      if (cmd_valid) busy_left = model_len;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic init, input logic wq, input logic [AW-1:0] wa,
                               input logic rq, input logic [AW-1:0] ra, input logic urg);
    init_done = init;
    wr_req    = wq;
    wr_addr   = wa;
    rd_req    = rq;
    rd_addr   = ra;
    rd_urgent = urg;
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic clear_logs();
    s_cmd.delete(); s_addr.delete(); s_cyc.delete();
    wa_cyc.delete(); ra_cyc.delete(); te_cyc.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cmd_valid) begin
      s_cmd.push_back(32'(cmd));
      s_addr.push_back(32'(cmd_addr));
      s_cyc.push_back(32'(cyc));
      if (prev_valid) b2b++;
    end
    prev_valid = cmd_valid;
    if (wr_ack) wa_cyc.push_back(32'(cyc));
    if (rd_ack) ra_cyc.push_back(32'(cyc));
    if (timeout_err) te_cyc.push_back(32'(cyc));
    if (wr_ack && rd_ack) dual++;
  endtask

  task automatic wait_for(input int which, input int bound, input string tag);
    int  n    = 0;
    logic seen = 1'b0;
    while (!seen && n < bound) begin
      tick();
      n++;
      case (which)
        EV_WR:     seen = wr_ack;
        EV_RD:     seen = rd_ack;
        EV_STROBE: seen = cmd_valid;
        default:   seen = timeout_err;
      endcase
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_cmd"},       32'(cmd),         32'd0);
    checkOutput({tag, "_valid"},     32'(cmd_valid),   32'd0);
    checkOutput({tag, "_addr"},      32'(cmd_addr),    32'd0);
    checkOutput({tag, "_wr_ack"},    32'(wr_ack),      32'd0);
    checkOutput({tag, "_rd_ack"},    32'(rd_ack),      32'd0);
    checkOutput({tag, "_timeout"},   32'(timeout_err), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_seq [6];
    int   fall;
    int   n;
    logic drop_rd;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single write, busy for 12 cycles.
    clear_logs();
    model_on  = 1'b1;
    model_len = 12;
    applyStimulus(1'b1, 1'b1, 22'h00123, 1'b0, '0, 1'b0);
    wait_for(EV_WR, 60, "single_wr_ack_seen");
    tick();
    wr_req = 1'b0;
    repeat (20) tick();
    checkOutput("single_strobes",   32'(s_cmd.size()), 32'd1);
    checkOutput("single_cmd",       qget(s_cmd, 0), 32'h4);
    checkOutput("single_addr",      qget(s_addr, 0), 32'h00123);
    checkOutput("single_ack_delay", qget(wa_cyc, 0) - qget(s_cyc, 0), 32'd14);
    checkOutput("single_wr_acks",   32'(wa_cyc.size()), 32'd1);
    checkOutput("single_rd_acks",   32'(ra_cyc.size()), 32'd0);

    // Urgent read wins over a pending write.
    clear_logs();
    applyStimulus(1'b1, 1'b1, 22'h00AAA, 1'b1, 22'h3FF00, 1'b1);
    wait_for(EV_RD, 60, "urgent_rd_ack_seen");
    tick();
    rd_req = 1'b0; rd_urgent = 1'b0;
    wait_for(EV_WR, 60, "urgent_wr_ack_seen");
    tick();
    wr_req = 1'b0;
    repeat (5) tick();
    checkOutput("urgent_strobes",  32'(s_cmd.size()), 32'd2);
    checkOutput("urgent_cmd0",     qget(s_cmd, 0), 32'h3);
    checkOutput("urgent_addr0",    qget(s_addr, 0), 32'h3FF00);
    checkOutput("urgent_cmd1",     qget(s_cmd, 1), 32'h4);
    checkOutput("urgent_addr1",    qget(s_addr, 1), 32'h00AAA);
    checkOutput("urgent_wr_after", qget(s_cyc, 1) - qget(ra_cyc, 0), 32'd2);

    // Write streak limit: four writes, then the waiting read, then writes resume.
    clear_logs();
    model_len = 3;
    applyStimulus(1'b1, 1'b1, 22'h00111, 1'b1, 22'h00222, 1'b0);
    n = 0;
    drop_rd = 1'b0;
    while (s_cmd.size() < 6 && n < 150) begin
      tick();
      n++;
      if (drop_rd) begin
        rd_req  = 1'b0;
        drop_rd = 1'b0;
      end
      if (rd_ack) drop_rd = 1'b1;
    end
    checkOutput("streak_strobes", 32'(s_cmd.size()), 32'd6);
    exp_seq = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h3, 32'h4};
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("streak_seq%0d", i), qget(s_cmd, i), exp_seq[i]);
    checkOutput("streak_rd_addr", qget(s_addr, 4), 32'h00222);
    wait_for(EV_WR, 40, "streak_last_ack_seen");
    tick();
    wr_req = 1'b0;
    repeat (10) tick();

    // Busy held for 40 cycles blocks any strobe.
    clear_logs();
    force_busy = 1'b1;
    applyStimulus(1'b1, 1'b1, 22'h2BEEF, 1'b0, '0, 1'b0);
    repeat (40) tick();
    checkOutput("gate_no_strobe", 32'(s_cmd.size()), 32'd0);
    force_busy = 1'b0;
    fall = cyc;
    wait_for(EV_STROBE, 10, "gate_strobe_seen");
    checkOutput("gate_strobe_delay", qget(s_cyc, 0) - 32'(fall), 32'd1);
    checkOutput("gate_addr", qget(s_addr, 0), 32'h2BEEF);
    wait_for(EV_WR, 40, "gate_wr_ack_seen");
    tick();
    wr_req = 1'b0;
    repeat (5) tick();

    // Controller never accepts: timeout, then the same command is reissued.
    clear_logs();
    model_on = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 22'h155AA, 1'b0);
    wait_for(EV_STROBE, 10, "to_first_strobe_seen");
    wait_for(EV_TO, 40, "to_pulse_seen");
    model_on = 1'b1;
    checkOutput("to_delay", qget(te_cyc, 0) - qget(s_cyc, 0), 32'd15);
    wait_for(EV_STROBE, 10, "to_restrobe_seen");
    checkOutput("to_restrobe_delay", qget(s_cyc, 1) - qget(s_cyc, 0), 32'd16);
    checkOutput("to_restrobe_cmd",   qget(s_cmd, 1), 32'h3);
    checkOutput("to_restrobe_addr",  qget(s_addr, 1), 32'h155AA);
    checkOutput("to_no_ack_before",  32'(ra_cyc.size()), 32'd0);
    wait_for(EV_RD, 60, "to_rd_ack_seen");
    checkOutput("to_pulses", 32'(te_cyc.size()), 32'd1);
    tick();
    rd_req = 1'b0;
    repeat (5) tick();

    // init_done low holds everything off; reset mid-transaction drops the ack.
    clear_logs();
    model_len = 12;
    applyStimulus(1'b0, 1'b1, 22'h0F0F0, 1'b1, 22'h30303, 1'b1);
    repeat (20) tick();
    checkOutput("init_no_strobe", 32'(s_cmd.size()), 32'd0);
    init_done = 1'b1;
    wait_for(EV_STROBE, 5, "init_strobe_seen");
    checkOutput("init_cmd", qget(s_cmd, 0), 32'h3);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    wait_for(EV_STROBE, 10, "rst_restrobe_seen");
    checkOutput("rst_restrobe_cmd",  qget(s_cmd, 1), 32'h3);
    checkOutput("rst_restrobe_addr", qget(s_addr, 1), 32'h30303);
    wait_for(EV_RD, 60, "rst_rd_ack_seen");
    checkOutput("rst_rd_acks", 32'(ra_cyc.size()), 32'd1);
    checkOutput("rst_wr_acks", 32'(wa_cyc.size()), 32'd0);
    tick();
    rd_req = 1'b0; rd_urgent = 1'b0;
    wait_for(EV_WR, 60, "rst_wr_ack_seen");
    checkOutput("rst_wr_addr", qget(s_addr, 2), 32'h0F0F0);
    tick();
    wr_req = 1'b0;
    repeat (5) tick();

    checkOutput("no_dual_ack",    32'(dual), 32'd0);
    checkOutput("no_b2b_strobe",  32'(b2b),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
